// File: rtl/vga_info_arbiter.sv
// vga_info_arbiter: shares the single port of the VGA character RAM between
// CPU MMIO writes and VGA scanout reads. VGA has priority. A pending CPU write
// wins once it has lost MAX_WAIT arbitrations in a row.
//
// Ports:
//   clock, reset           - 50 MHz clock, synchronous active-high reset
//   cpu_req/addr/wdata     - CPU write request, held until cpu_ack
//   cpu_ack                - one-cycle pulse, write committed at end of cycle
//   vga_req/addr           - VGA read request
//   vga_ack                - one-cycle pulse, read address accepted
//   vga_valid/rdata        - read data strobe (rdata passes mem_rdata through)
//   mem_en/we/addr/wdata   - RAM port controls (registered)
//   mem_rdata              - RAM read data, one cycle after a read enable
//   busy                   - arbiter not idle
module vga_info_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Keep at least one bit so MAX_WAIT = 0 still elaborates.
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] MaxCnt = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdData, StWr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             grant_cpu, grant_vga, cpu_elig;

  assign vga_rdata = mem_rdata;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_cpu  = 1'b0;
    grant_vga  = 1'b0;
    // A just-acknowledged write must not be granted twice.
    cpu_elig   = cpu_req && (state_q != StWr);

    if (state_q == StRdIssue) begin
      state_d = StRdData;
    end else begin
      if (cpu_elig && vga_req) begin
        if (wait_cnt_q == MaxCnt) grant_cpu = 1'b1;
        else                      grant_vga = 1'b1;
      end else if (cpu_elig) begin
        grant_cpu = 1'b1;
      end else if (vga_req) begin
        grant_vga = 1'b1;
      end

      if (grant_cpu)      state_d = StWr;
      else if (grant_vga) state_d = StRdIssue;
      else                state_d = StIdle;

      if (grant_cpu || !cpu_req) begin
        wait_cnt_d = '0;
      end else if (cpu_elig && grant_vga && (wait_cnt_q != MaxCnt)) begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      cpu_ack    <= 1'b0;
      vga_ack    <= 1'b0;
      vga_valid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cpu_ack    <= (state_d == StWr);
      vga_ack    <= (state_d == StRdIssue);
      vga_valid  <= (state_d == StRdData);
      mem_en     <= (state_d == StWr) || (state_d == StRdIssue);
      mem_we     <= (state_d == StWr);
      busy       <= (state_d != StIdle);
      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (grant_vga) begin
        mem_addr  <= vga_addr;
      end
    end
  end

endmodule
